// File: rtl/mem_stage_wait.sv
// MEM pipeline stage: data memory with configurable wait states, stall handshake and MEM/WB register.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range accesses are suppressed and flagged on mem_err.
module mem_stage_wait #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RD_W        = 3,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              ResultSrc_MEM,
  input  logic              RegWrite_MEM,
  input  logic [RD_W-1:0]   rd_MEM,
  input  logic [DATA_W-1:0] alu_result_MEM,
  input  logic [DATA_W-1:0] write_data_MEM,
  output logic              stall_mem,
  output logic [DATA_W-1:0] fwd_data_MEM,
  output logic [DATA_W-1:0] mem_data_WB,
  output logic [DATA_W-1:0] alu_result_WB,
  output logic              ResultSrc_WB,
  output logic              RegWrite_WB,
`ifdef MEM_BOUNDS_CHECK_EN
  output logic              mem_err,
`endif
  output logic [RD_W-1:0]   rd_WB
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               access;
  logic               complete;
  logic               oob;
  logic [ADDR_W-1:0]  idx;
  logic [DATA_W-1:0]  rdata;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign access = MemRead_MEM | MemWrite_MEM;
  assign idx    = alu_result_MEM[ADDR_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob   = access && (alu_result_MEM[DATA_W-1:ADDR_W] != '0);
  assign rdata = oob ? '0 : mem[idx];
`else
  assign oob   = 1'b0;
  assign rdata = mem[idx];
`endif

  assign fwd_data_MEM = ResultSrc_MEM ? rdata : alu_result_MEM;

  // Flush overrides the FSM; completion is the only cycle an access may commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_mem = 1'b0;
    complete  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access && (WAIT_CYCLES > 0)) begin
            stall_mem = 1'b1;
            state_d   = WAIT;
            cnt_d     = CNT_INIT;
          end else begin
            complete = 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            stall_mem = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
          end else begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
    end else if (complete && MemWrite_MEM && !oob) begin
      mem[idx] <= write_data_MEM;
    end
  end

  // Stalled or flushed cycles insert a bubble so each instruction reaches WB once.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_WB   <= '0;
      alu_result_WB <= '0;
      ResultSrc_WB  <= 1'b0;
      RegWrite_WB   <= 1'b0;
      rd_WB         <= '0;
    end else if (complete) begin
      mem_data_WB   <= rdata;
      alu_result_WB <= alu_result_MEM;
      ResultSrc_WB  <= ResultSrc_MEM;
      RegWrite_WB   <= RegWrite_MEM;
      rd_WB         <= rd_MEM;
    end else begin
      RegWrite_WB   <= 1'b0;
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) mem_err <= 1'b0;
    else       mem_err <= complete && oob;
  end
`endif

endmodule
